// File: rtl/sequential_left_shift_if.sv
// Operand/result bundle for the sequential left shifter.
// The master drives start/in/amt; the slave (shifter) drives out/busy/done/ovf.
interface sequential_left_shift_if;
    logic        start;
    logic [16:0] in;
    logic [4:0]  amt;
    logic [16:0] out;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output start, in, amt,
        input  out, busy, done, ovf
    );

    modport slave (
        input  start, in, amt,
        output out, busy, done, ovf
    );
endinterface

// File: rtl/sequential_left_shift.sv
// Shifts a 17-bit two's-complement operand left one bit per cycle with optional saturation.
// Latency amt+1 cycles; start is ignored while busy, accepted in IDLE and DONE.
module sequential_left_shift #(
    parameter bit SAT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    sequential_left_shift_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] out_q,   out_d;
    logic [4:0]  count_q, count_d;
    logic        sign_q,  sign_d;
    logic        ovf_q,   ovf_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic        ovf_step;
    logic [16:0] sat_val;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        count_d  = count_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        // Sign bit about to be lost differs from the one replacing it.
        ovf_step = out_q[16] ^ out_q[15];
        // Saturation direction follows the operand as loaded, not the current bits.
        sat_val  = sign_q ? 17'h10000 : 17'h0FFFF;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    out_d   = bus.in;
                    count_d = bus.amt;
                    sign_d  = bus.in[16];
                    ovf_d   = 1'b0;
                    if (bus.amt != 5'd0) begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                out_d   = {out_q[15:0], 1'b0};
                count_d = count_q - 5'd1;
                ovf_d   = ovf_q | ovf_step;
                if (count_q == 5'd1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (SAT && ovf_d) begin
                        out_d = sat_val;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule
